// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle for the round-robin FIFO write arbiter.
// Arbiter connects through the slave modport; the environment (producers plus
// FIFO flags) drives through the master modport.
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic                  fifo_full;
    logic                  fifo_rd_en;
    logic                  fifo_empty;
    logic                  fifo_wr_en;
    logic [WIDTH-1:0]      fifo_w_data;
    logic [CW-1:0]         credits;
    logic                  ovf_err;

    modport master (
        output req, req_data, fifo_full, fifo_rd_en, fifo_empty,
        input  gnt, fifo_wr_en, fifo_w_data, credits, ovf_err
    );

    modport slave (
        input  req, req_data, fifo_full, fifo_rd_en, fifo_empty,
        output gnt, fifo_wr_en, fifo_w_data, credits, ovf_err
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// Grant is combinational; the FIFO write is issued one cycle later from
// registers. A credit counter reserves a slot at grant time so the delayed
// write can never land in a full FIFO; ovf_err latches if one ever does.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);
    localparam logic [LW-1:0] LAST_RST = LW'(NREQ - 1);

    // Per-producer view of the flat data bus (same bit layout).
    logic [NREQ-1:0][WIDTH-1:0] lane_data;
    assign lane_data = bus.req_data;

    logic [LW-1:0]    last_q,      last_d;
    logic [CW-1:0]    credits_q,   credits_d;
    logic             wr_en_q,     wr_en_d;
    logic [WIDTH-1:0] w_data_q,    w_data_d;
    logic             ovf_q,       ovf_d;

    logic [NREQ-1:0]  gnt_c;
    logic [LW-1:0]    win;
    logic [LW-1:0]    cand;
    logic             found;
    logic             accept;
    logic             inc;

    // Rotating search from last+1; grant only with a free credit and out of reset.
    always_comb begin
        gnt_c = '0;
        win   = last_q;
        cand  = last_q;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = LW'((int'(last_q) + k) % NREQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        if (found && (credits_q != '0) && rst)
            gnt_c[win] = 1'b1;
    end

    // Next-state: write register, pointer, credit bookkeeping, sticky overflow.
    always_comb begin
        accept    = |gnt_c;
        inc       = bus.fifo_rd_en & ~bus.fifo_empty;
        wr_en_d   = accept;
        w_data_d  = accept ? lane_data[win] : w_data_q;
        last_d    = accept ? win : last_q;
        credits_d = credits_q;
        if (inc && !accept && (credits_q != CRED_MAX))
            credits_d = credits_q + CW'(1);
        else if (accept && !inc)
            credits_d = credits_q - CW'(1);
        ovf_d     = ovf_q | (wr_en_q & bus.fifo_full);
    end

    // State registers; reset leaves req[0] with first priority and all slots free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q    <= LAST_RST;
            credits_q <= CRED_MAX;
            wr_en_q   <= 1'b0;
            w_data_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            last_q    <= last_d;
            credits_q <= credits_d;
            wr_en_q   <= wr_en_d;
            w_data_q  <= w_data_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.gnt         = gnt_c;
    assign bus.fifo_wr_en  = wr_en_q;
    assign bus.fifo_w_data = w_data_q;
    assign bus.credits     = credits_q;
    assign bus.ovf_err     = ovf_q;
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares a single synchronous FIFO write port between NREQ producers. Each cycle it selects at most one requesting producer, returns a same-cycle grant, and drives the FIFO write port one cycle later from registered outputs. An internal credit counter tracks free FIFO slots so that the one-cycle write latency can never overflow the FIFO. A sticky error flag catches any integration fault that still writes into a full FIFO.

## Interface
- NREQ, 4: number of producers (2..8)
- WIDTH, 4: data width, equal to the FIFO WIDTH
- DEPTH, 8: FIFO depth, equal to the FIFO DEPTH
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- req  in  NREQ  per-producer write request, level
- req_data  in  NREQ*WIDTH  producer data; producer i drives bits [i*WIDTH +: WIDTH]
- gnt  out  NREQ  combinational one-hot grant; req[i] & gnt[i] at a rising edge = word accepted
- fifo_full  in  1  FIFO full flag
- fifo_rd_en  in  1  consumer read enable at the FIFO
- fifo_empty  in  1  FIFO empty flag
- fifo_wr_en  out  1  registered FIFO write enable
- fifo_w_data  out  WIDTH  registered FIFO write data
- credits  out  clog2(DEPTH)+1  free slots as seen by the arbiter (0..DEPTH)
- ovf_err  out  1  sticky: fifo_wr_en was high while fifo_full was high

## Operation
- State: last-grant pointer `last` (clog2(NREQ) bits), `credits` counter, output registers, and `ovf_err`.
- Arbitration (combinational):
  - Allowed only when credits != 0.
  - The search order starts at index last+1 mod NREQ and wraps.
  - The first i with req[i]=1 gets gnt[i]=1. All other gnt bits are 0.
  - gnt is all-zero if no req or credits == 0.
  - gnt does not depend on fifo_full, which is stale by one write.
- Accept edge (any gnt bit high):
  - fifo_wr_en <= 1
  - fifo_w_data <= slice of the winner
  - last <= winner
- No-accept edge:
  - fifo_wr_en <= 0
  - fifo_w_data holds its value
  - last holds its value
- Credits, evaluated every edge:
  - inc = fifo_rd_en & ~fifo_empty
  - dec = accept
  - credits <= credits + inc - dec; inc and dec on the same edge leave credits unchanged.
  - Credits never exceed DEPTH and never go below 0. An inc while credits == DEPTH is ignored and does not wrap.
- ovf_err:
  - Set on any edge where fifo_wr_en & fifo_full.
  - Cleared only by reset.
- Producers keep req and req_data stable until they see their gnt bit at a rising edge. They may drop req only after acceptance.

## Timing
- Reset (rst=0, asynchronous), all values applied immediately:
  - fifo_wr_en=0
  - fifo_w_data=0
  - credits=DEPTH
  - ovf_err=0
  - last=NREQ-1, so req[0] has first priority after reset
  - gnt=0 while rst=0
- Reset deassertion is synchronous to clk at integration. The first accept is possible on the first edge with rst=1.
- Latency: accept at edge k causes fifo_wr_en=1 during cycle k..k+1. The FIFO stores the word at edge k+1.
- Throughput: one word per cycle while credits > 0.
- Fairness: a continuously requesting producer waits at most NREQ-1 grants.
- Credits fall to 0 after DEPTH accepts with no reads. gnt is 0 from then on until a read edge with fifo_empty=0.
- Reset mid-operation: a pending fifo_wr_en is dropped. The FIFO is reset by the same reset, so credits=DEPTH stays consistent with the FIFO.

## Test plan
- Reset, then req=4'b0001 with data0=4'hA for one cycle:
  - gnt=4'b0001 in the same cycle.
  - Next cycle fifo_wr_en=1, fifo_w_data=4'hA.
  - credits goes 8→7.
- req=4'b1111 held for 8 edges with distinct data 1,2,3,4 and no reads:
  - Grant order is 0,1,2,3,0,1,2,3.
  - credits reaches 0.
  - gnt=0 on the 9th edge; fifo_full goes 1; ovf_err stays 0.
- From credits=0, pulse fifo_rd_en with fifo_empty=0 while req=4'b0100:
  - credits goes 0→1, then gnt=4'b0100 is accepted.
  - credits goes back to 0.
- With credits=3, a read and an accept on the same edge: credits stays 3.
- Integration fault, fifo_full forced to 1 during a fifo_wr_en=1 cycle:
  - ovf_err=1 and stays 1 until rst=0.
- Drive rst=0 mid-burst, between clock edges:
  - fifo_wr_en=0, credits=8 and gnt=0 immediately.
  - After release, req=4'b1001 grants index 0 first.
